keypad_scan_ctrl: RTL

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_pkg.sv | 14 +
 rtl/keypad_debounce.sv | 53 +++++
 rtl/keypad_scan_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared sizes, key-vector type and FSM states for the 4x4 keypad scanner.
package keypad_pkg;
    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;
    localparam int N_KEYS = N_ROWS * N_COLS;

    typedef logic [N_KEYS-1:0] key_vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LOCKED  = 2'd2
    } kp_state_t;
endpackage

// File: rtl/keypad_debounce.sv
// Whole-matrix debouncer: a snapshot is accepted once it has repeated
// DEBOUNCE_SCANS times in a row; deb_upd pulses in the cycle deb is loaded.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  key_vec_t snap,
    input  logic     snap_done,
    output key_vec_t deb,
    output logic     deb_upd
);
    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);

    key_vec_t   prev_reg;
    key_vec_t   deb_reg;
    logic [3:0] stable_cnt_reg;
    logic [3:0] stable_cnt_next;
    logic       deb_upd_reg;

    always_comb begin
        stable_cnt_next = '0;
        if (snap == prev_reg) begin
            stable_cnt_next = (stable_cnt_reg == CNT_MAX) ? stable_cnt_reg
                                                          : stable_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_reg       <= '0;
            deb_reg        <= '0;
            stable_cnt_reg <= '0;
            deb_upd_reg    <= 1'b0;
        end else begin
            deb_upd_reg <= 1'b0;
            if (snap_done) begin
                prev_reg       <= snap;
                stable_cnt_reg <= stable_cnt_next;
                // Load only on the transition into saturation, never while saturated.
                if (stable_cnt_next == CNT_MAX && stable_cnt_reg != CNT_MAX) begin
                    deb_reg     <= snap;
                    deb_upd_reg <= 1'b1;
                end
            end
        end
    end

    assign deb     = deb_reg;
    assign deb_upd = deb_upd_reg;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, synchronised row sampling, debounce and a
// single-key press/release FSM with multi-key lockout.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic        key_release
);
    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);

    logic [N_ROWS-1:0] row_meta_reg;
    logic [N_ROWS-1:0] row_sync_reg;
    logic [15:0]       dwell_reg;
    logic [1:0]        col_reg;
    logic              dwell_end;
    key_vec_t          snap_reg;
    key_vec_t          snap_next;
    logic              snap_done_reg;

    key_vec_t          deb;
    logic              deb_upd;

    kp_state_t         state_reg;
    logic [3:0]        key_code_reg;
    logic              key_valid_reg;
    logic              key_held_reg;
    logic              key_release_reg;

    logic [3:0]        enc_idx;
    logic [4:0]        bit_cnt;
    logic              deb_onehot;
    logic              deb_zero;
    key_vec_t          held_vec;

    assign dwell_end = (dwell_reg == DWELL_LAST);
    assign col_out   = ~(4'b0001 << col_reg);

    // Each key bit captures its row only in the last dwell cycle of its column.
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_snap
        assign snap_next[gi] = (dwell_end && col_reg == 2'(gi % N_COLS))
                               ? ~row_sync_reg[gi / N_COLS] : snap_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta_reg  <= '0;
            row_sync_reg  <= '0;
            dwell_reg     <= '0;
            col_reg       <= '0;
            snap_reg      <= '0;
            snap_done_reg <= 1'b0;
        end else begin
            row_meta_reg  <= row_in;
            row_sync_reg  <= row_meta_reg;
            snap_reg      <= snap_next;
            snap_done_reg <= dwell_end && (col_reg == 2'd3);
            if (dwell_end) begin
                dwell_reg <= '0;
                col_reg   <= col_reg + 2'd1;
            end else begin
                dwell_reg <= dwell_reg + 16'd1;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .snap      (snap_reg),
        .snap_done (snap_done_reg),
        .deb       (deb),
        .deb_upd   (deb_upd)
    );

    always_comb begin
        enc_idx = '0;
        bit_cnt = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (deb[i]) begin
                enc_idx = 4'(i);
                bit_cnt = bit_cnt + 5'd1;
            end
        end
    end

    assign deb_onehot = (bit_cnt == 5'd1);
    assign deb_zero   = (deb == '0);
    assign held_vec   = key_vec_t'(1) << key_code_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            key_code_reg    <= '0;
            key_valid_reg   <= 1'b0;
            key_held_reg    <= 1'b0;
            key_release_reg <= 1'b0;
        end else begin
            key_valid_reg   <= 1'b0;
            key_release_reg <= 1'b0;
            if (deb_upd) begin
                case (state_reg)
                    IDLE: begin
                        if (deb_onehot) begin
                            state_reg     <= PRESSED;
                            key_code_reg  <= enc_idx;
                            key_valid_reg <= 1'b1;
                            key_held_reg  <= 1'b1;
                        end else if (!deb_zero) begin
                            state_reg <= LOCKED;
                        end
                    end
                    PRESSED: begin
                        if (deb_zero) begin
                            state_reg       <= IDLE;
                            key_release_reg <= 1'b1;
                            key_held_reg    <= 1'b0;
                        end else if (deb != held_vec) begin
                            state_reg    <= LOCKED;
                            key_held_reg <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        if (deb_zero) begin
                            state_reg       <= IDLE;
                            key_release_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg    <= IDLE;
                        key_held_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign key_code    = key_code_reg;
    assign key_valid   = key_valid_reg;
    assign key_held    = key_held_reg;
    assign key_release = key_release_reg;
endmodule
